// File: rtl/clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_set_ctrl                                               |
// | Description : Clock time-setting FSM that edits hour/min/sec, blinks the   |
// |               field being edited and loads the result into time_count.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_set_ctrl #(
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       set_mode,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic [5:0] blank
);

    localparam int c_BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int c_TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_HALF - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_ST_RUN  = 2'd0;
    localparam logic [1:0] c_ST_HOUR = 2'd1;
    localparam logic [1:0] c_ST_MIN  = 2'd2;
    localparam logic [1:0] c_ST_SEC  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_set_mode;
    logic                 r_load;
    logic [4:0]           r_hour;
    logic [5:0]           r_min;
    logic [5:0]           r_sec;
    logic [5:0]           r_blank;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic [c_TMO_W-1:0]   r_tmo;

    logic [1:0]           w_state_nx;
    logic                 w_load_nx;
    logic [4:0]           w_hour_nx;
    logic [5:0]           w_min_nx;
    logic [5:0]           w_sec_nx;
    logic [5:0]           w_blank_nx;
    logic [c_BLINK_W-1:0] w_blink_cnt_nx;
    logic                 w_phase_nx;
    logic [c_TMO_W-1:0]   w_tmo_nx;
    logic                 w_step;

    // inc and dec together cancel out but still count as activity
    assign w_step = key_inc ^ key_dec;

    always_comb begin
        w_state_nx     = r_state;
        w_load_nx      = 1'b0;
        w_hour_nx      = r_hour;
        w_min_nx       = r_min;
        w_sec_nx       = r_sec;
        w_blink_cnt_nx = '0;
        w_phase_nx     = 1'b0;
        w_tmo_nx       = '0;
        if (r_state == c_ST_RUN) begin
            if (key_mode) begin
                w_state_nx = c_ST_HOUR;
                w_hour_nx  = cur_hour;
                w_min_nx   = cur_min;
                w_sec_nx   = cur_sec;
            end
        end else if (key_mode) begin
            case (r_state)
                c_ST_HOUR: w_state_nx = c_ST_MIN;
                c_ST_MIN:  w_state_nx = c_ST_SEC;
                default: begin
                    w_state_nx = c_ST_RUN;
                    w_load_nx  = 1'b1;
                end
            endcase
        end else if (key_inc || key_dec) begin
            if (w_step) begin
                case (r_state)
                    c_ST_HOUR: begin
                        if (key_inc) w_hour_nx = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                        else         w_hour_nx = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
                    end
                    c_ST_MIN: begin
                        if (key_inc) w_min_nx = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                        else         w_min_nx = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
                    end
                    default: begin
                        if (key_inc) w_sec_nx = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                        else         w_sec_nx = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
                    end
                endcase
            end
        end else if (r_tmo == c_TMO_LAST) begin
            w_state_nx = c_ST_RUN;
        end else begin
            w_tmo_nx = r_tmo + c_TMO_W'(1);
            if (r_blink_cnt == c_BLINK_LAST) begin
                w_blink_cnt_nx = '0;
                w_phase_nx     = ~r_phase;
            end else begin
                w_blink_cnt_nx = r_blink_cnt + c_BLINK_W'(1);
                w_phase_nx     = r_phase;
            end
        end
    end

    // Mask is derived from next-state values so it lines up with the registered state
    always_comb begin
        w_blank_nx = 6'b000000;
        if (w_phase_nx) begin
            case (w_state_nx)
                c_ST_HOUR: w_blank_nx = 6'b110000;
                c_ST_MIN:  w_blank_nx = 6'b001100;
                c_ST_SEC:  w_blank_nx = 6'b000011;
                default:   w_blank_nx = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_RUN;
            r_set_mode  <= 1'b0;
            r_load      <= 1'b0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_blank     <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_set_mode  <= (w_state_nx != c_ST_RUN);
            r_load      <= w_load_nx;
            r_hour      <= w_hour_nx;
            r_min       <= w_min_nx;
            r_sec       <= w_sec_nx;
            r_blank     <= w_blank_nx;
            r_blink_cnt <= w_blink_cnt_nx;
            r_phase     <= w_phase_nx;
            r_tmo       <= w_tmo_nx;
        end
    end

    assign set_mode  = r_set_mode;
    assign load      = r_load;
    assign load_hour = r_hour;
    assign load_min  = r_min;
    assign load_sec  = r_sec;
    assign blank     = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clock_set_ctrl                                            |
// | Description : Directed self-checking bench for clock_set_ctrl with a       |
// |               field/idle/age behavioural model checked every cycle.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clock_set_ctrl;

    localparam int c_BH  = 4;
    localparam int c_TMO = 20;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc  = 1'b0;
    logic       key_dec  = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min  = '0;
    logic [5:0] cur_sec  = '0;
    logic       set_mode;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [5:0] blank;

    int n_checks = 0;
    int n_errors = 0;
    bit compare_en = 1'b0;

    // Model: field 0 = running, 1/2/3 = hour/min/sec being edited
    int m_field;
    int m_val [1:3];
    int m_idle;
    int m_age;
    bit m_load;

    clock_set_ctrl #(
        .BLINK_HALF  (c_BH),
        .TIMEOUT_CYC (c_TMO)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .set_mode  (set_mode),
        .load      (load),
        .load_hour (load_hour),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    function automatic int modulus(input int f);
        return (f == 1) ? 24 : 60;
    endfunction

    function automatic int exp_blank(input int f, input int age);
        if (f == 0 || ((age / c_BH) % 2) == 0) return 0;
        return 3 << (2 * (3 - f));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_field <= 0;
            m_val   <= '{0, 0, 0};
            m_idle  <= 0;
            m_age   <= 0;
            m_load  <= 1'b0;
        end else begin : upd
            int f, idle, age;
            int v [1:3];
            bit ld;
            f = m_field; v = m_val; idle = m_idle; age = m_age; ld = 1'b0;
            if (f == 0) begin
                if (key_mode) begin
                    f = 1; idle = 0; age = 0;
                    v[1] = int'(cur_hour); v[2] = int'(cur_min); v[3] = int'(cur_sec);
                end
            end else if (key_mode) begin
                if (f == 3) begin f = 0; ld = 1'b1; end
                else f = f + 1;
                idle = 0; age = 0;
            end else if (key_inc || key_dec) begin
                idle = 0; age = 0;
                if (key_inc && !key_dec) v[f] = (v[f] + 1) % modulus(f);
                else if (key_dec && !key_inc) v[f] = (v[f] + modulus(f) - 1) % modulus(f);
            end else if (idle >= c_TMO - 1) begin
                f = 0;
            end else begin
                idle++; age++;
            end
            m_field <= f; m_val <= v; m_idle <= idle; m_age <= age; m_load <= ld;
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check("cyc set_mode",  int'(set_mode),  int'(m_field != 0));
            check("cyc load",      int'(load),      int'(m_load));
            check("cyc load_hour", int'(load_hour), m_val[1]);
            check("cyc load_min",  int'(load_min),  m_val[2]);
            check("cyc load_sec",  int'(load_sec),  m_val[3]);
            check("cyc blank",     int'(blank),     exp_blank(m_field, m_age));
        end
    end

    task automatic press(input logic m, input logic i, input logic d);
        key_mode = m; key_inc = i; key_dec = d;
        @(negedge clk);
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1 compare_en = 1'b1;
        check("rst set_mode", int'(set_mode), 0);
        check("rst load", int'(load), 0);
        check("rst blank", int'(blank), 0);
        check("rst load_hour", int'(load_hour), 0);
        idle(2);
        rstn = 1'b1;

        // 1: entry captures live time, hour field blinks every 4 cycles
        set_cur(12, 34, 56);
        press(1, 0, 0);
        check("t1 set_mode", int'(set_mode), 1);
        check("t1 hour", int'(load_hour), 12);
        check("t1 min", int'(load_min), 34);
        check("t1 sec", int'(load_sec), 56);
        check("t1 blank vis", int'(blank), 0);
        idle(4);
        check("t1 blank off", int'(blank), int'(6'b110000));
        idle(4);
        check("t1 blank vis2", int'(blank), 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        check("t1 load", int'(load), 1);
        check("t1 set_mode exit", int'(set_mode), 0);

        // 2: wrap boundaries on every field
        set_cur(23, 0, 59);
        press(1, 0, 0);
        press(0, 1, 0); check("t2 hour inc wrap", int'(load_hour), 0);
        press(0, 0, 1); check("t2 hour dec wrap", int'(load_hour), 23);
        press(0, 1, 0);
        press(1, 0, 0);
        idle(4);        check("t2 min blank", int'(blank), int'(6'b001100));
        press(0, 0, 1); check("t2 min dec wrap", int'(load_min), 59);
        check("t2 blank after edit", int'(blank), 0);
        press(0, 1, 0); check("t2 min inc wrap", int'(load_min), 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 1, 0); check("t2 sec inc wrap", int'(load_sec), 0);
        press(0, 0, 1); check("t2 sec dec wrap", int'(load_sec), 59);
        press(0, 1, 0);
        press(1, 0, 0);
        check("t2 load", int'(load), 1);
        check("t2 load hour", int'(load_hour), 0);
        check("t2 load min", int'(load_min), 59);
        check("t2 load sec", int'(load_sec), 0);

        // 3: full edit sequence -> 14:33:56
        set_cur(12, 34, 56);
        press(1, 0, 0); press(0, 1, 0); press(0, 1, 0); press(1, 0, 0);
        press(0, 0, 1); press(1, 0, 0); press(1, 0, 0);
        check("t3 load", int'(load), 1);
        check("t3 hour", int'(load_hour), 14);
        check("t3 min", int'(load_min), 33);
        check("t3 sec", int'(load_sec), 56);
        check("t3 set_mode", int'(set_mode), 0);
        idle(1);
        check("t3 load one cycle", int'(load), 0);

        // 4: timeout after 20 idle cycles, restarted by a key at cycle 15
        set_cur(1, 2, 3);
        press(1, 0, 0); press(1, 0, 0);
        idle(19); check("t4 still set", int'(set_mode), 1);
        idle(1);
        check("t4 timed out", int'(set_mode), 0);
        check("t4 no load", int'(load), 0);
        check("t4 blank", int'(blank), 0);
        press(1, 0, 0);
        idle(14);
        press(0, 0, 1);
        idle(19); check("t4 restart set", int'(set_mode), 1);
        check("t4 restart hour", int'(load_hour), 0);
        idle(1);  check("t4 restart out", int'(set_mode), 0);

        // 5: simultaneous keys
        set_cur(12, 34, 56);
        press(1, 0, 0);
        press(1, 1, 0);
        check("t5 hour kept", int'(load_hour), 12);
        idle(4); check("t5 in min", int'(blank), int'(6'b001100));
        idle(6);
        press(0, 1, 1);
        check("t5 min kept", int'(load_min), 34);
        idle(19); check("t5 tmo cleared", int'(set_mode), 1);
        idle(1);  check("t5 tmo out", int'(set_mode), 0);

        // 6: async reset mid-edit, inc/dec ignored afterwards in RUN
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 0);
        check("t6 sec edit", int'(load_sec), 57);
        #2 rstn = 1'b0;
        #1;
        check("t6 async set_mode", int'(set_mode), 0);
        check("t6 async sec", int'(load_sec), 0);
        check("t6 async hour", int'(load_hour), 0);
        check("t6 async blank", int'(blank), 0);
        idle(1);
        rstn = 1'b1;
        press(0, 1, 0); press(0, 0, 1);
        check("t6 run ignores", int'(set_mode), 0);
        check("t6 run hour", int'(load_hour), 0);
        check("t6 run sec", int'(load_sec), 0);
        press(1, 0, 0);
        check("t6 reenter", int'(set_mode), 1);
        check("t6 reenter sec", int'(load_sec), 56);

        idle(2);
        compare_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
